// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with a final sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_nxt;
  logic                 is_div_q, neg_res, neg_rem;
  logic [WIDTH-1:0]     divisor;
  logic [2*WIDTH-1:0]   acc, acc_step, prod_fix;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH:0]       add_sum, trial;
  logic [WIDTH-1:0]     quot_fix, rem_fix, abs_a, abs_b;
  logic                 a_neg, b_neg, accept, dz_req;

  // op[0]==0 selects the signed variants
  assign a_neg  = ~op[0] & a[WIDTH-1];
  assign b_neg  = ~op[0] & b[WIDTH-1];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;
  assign accept = (state == IDLE) & start & ~abort;
  assign dz_req = accept & op[1] & (b == '0);
  assign busy   = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !dz_req) state_nxt = CALC;
      CALC: if (abort) state_nxt = IDLE;
            else if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc = {high, low}: multiply keeps {partial product, multiplier},
  // divide keeps {remainder, dividend/quotient}; both start as {0, |a|}.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? divisor : {WIDTH{1'b0}})};
    trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};
    if (is_div_q)
      acc_step = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {add_sum, acc[WIDTH-1:1]};
  end

  // Quotient is negated when signs differ; remainder follows the dividend.
  assign prod_fix = neg_res ? -acc : acc;
  assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      divisor  <= '0;
      acc      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          div_zero <= dz_req;
          done     <= dz_req;
          if (!dz_req) begin
            is_div_q <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            divisor  <= abs_b;
            acc      <= {{WIDTH{1'b0}}, abs_a};
            cnt      <= CNT_W'(WIDTH);
          end
        end
        CALC: if (!abort) begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
        end
        FIX: if (!abort) begin
          {hi, lo} <= is_div_q ? {rem_fix, quot_fix} : prod_fix;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: 32- and 8-bit instances checked against a plain
// integer-arithmetic model of HI/LO, with handshake corner cases.
module tb_mult_div_unit;

  logic        clock = 1'b0, reset = 1'b0, abort = 1'b0;
  logic        start32 = 1'b0, start8 = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a32 = '0, b32 = '0, hi32, lo32;
  logic [7:0]  a8 = '0, b8 = '0, hi8, lo8;
  logic        busy32, done32, dz32, busy8, done8, dz8;

  int nvec = 0, nerr = 0;
  longint mh[2], ml[2];
  bit     mdz[2];

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .abort(abort), .op(op),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .div_zero(dz32),
    .hi(hi32), .lo(lo32));

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .abort(abort), .op(op),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .div_zero(dz8),
    .hi(hi8), .lo(lo8));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic snap(input int w, output logic bsy, output logic dn, output logic dz,
                      output logic [63:0] h, output logic [63:0] l);
    if (w == 8) begin bsy = busy8;  dn = done8;  dz = dz8;  h = {56'd0, hi8};  l = {56'd0, lo8};  end
    else        begin bsy = busy32; dn = done32; dz = dz32; h = {32'd0, hi32}; l = {32'd0, lo32}; end
  endtask

  // HI/LO from the architectural definition using 64-bit integer arithmetic
  function automatic void model(input int w, input logic [1:0] o, input longint x, input longint y,
                                inout longint h, inout longint l, output bit dz);
    longint m, sx, sy, p, q, r;
    m  = (longint'(1) << w) - 1;
    sx = ((x ^ (longint'(1) << (w-1))) & m) - (longint'(1) << (w-1));
    sy = ((y ^ (longint'(1) << (w-1))) & m) - (longint'(1) << (w-1));
    dz = 1'b0;
    if (!o[1]) begin
      p = o[0] ? x * y : sx * sy;
      h = (p >> w) & m;
      l = p & m;
    end else if (y == 0) begin
      dz = 1'b1;
    end else begin
      q = o[0] ? x / y : sx / sy;
      r = o[0] ? x % y : sx % sy;
      h = r & m;
      l = q & m;
    end
  endfunction

  // mode 0: plain op; 1: extra start pulse sampled at edge k; 2: abort sampled at edge k
  task automatic run(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int mode, input int k);
    int idx, n, nb, seen;
    bit dz;
    logic bsy, dn, dzo;
    logic [63:0] h, l;
    longint eh, el, xm, ym;
    idx = (w == 8) ? 1 : 0;
    xm  = (w == 8) ? longint'(x[7:0]) : longint'(x);
    ym  = (w == 8) ? longint'(y[7:0]) : longint'(y);
    @(negedge clock);
    op = o;
    if (w == 8) begin a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
    else        begin a32 = x; b32 = y; start32 = 1'b1; end
    @(posedge clock); #1;
    start8 = 1'b0; start32 = 1'b0;
    op = 2'($urandom); a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    eh = mh[idx]; el = ml[idx];
    model(w, o, xm, ym, eh, el, dz);
    snap(w, bsy, dn, dzo, h, l);
    if (dz) begin
      chk("dz_done", 64'(dn), 64'd1);
      chk("dz_flag", 64'(dzo), 64'd1);
      chk("dz_busy", 64'(bsy), 64'd0);
      chk("dz_hi", h, 64'(mh[idx]));
      chk("dz_lo", l, 64'(ml[idx]));
      mdz[idx] = 1'b1;
      return;
    end
    chk("dz_clr", 64'(dzo), 64'd0);
    mdz[idx] = 1'b0;
    nb = int'(bsy); n = 0;
    while (!dn && n < w + 8) begin
      if (mode != 0 && n + 1 == k) begin
        @(negedge clock);
        if (mode == 1) begin op = 2'b01; a32 = 32'd3; b32 = 32'd3; start32 = 1'b1; start8 = (w == 8); end
        else abort = 1'b1;
      end
      @(posedge clock); #1;
      start32 = 1'b0; start8 = 1'b0; abort = 1'b0;
      n++;
      snap(w, bsy, dn, dzo, h, l);
      nb += int'(bsy);
      if (mode == 2 && n == k) break;
    end
    if (mode == 2) begin
      chk("abort_busy", 64'(bsy), 64'd0);
      seen = int'(dn);
      repeat (w + 4) begin
        @(posedge clock); #1;
        snap(w, bsy, dn, dzo, h, l);
        seen += int'(dn);
      end
      chk("abort_done", 64'(seen), 64'd0);
      chk("abort_hi", h, 64'(mh[idx]));
      chk("abort_lo", l, 64'(ml[idx]));
      return;
    end
    chk("latency", 64'(n), 64'(w + 1));
    chk("busy_cyc", 64'(nb), 64'(w + 1));
    chk("hi", h, 64'(eh));
    chk("lo", l, 64'(el));
    mh[idx] = eh; ml[idx] = el;
  endtask

  initial begin
    logic bsy, dn, dzo;
    logic [63:0] h, l;
    logic [31:0] y;
    mh[0] = 0; ml[0] = 0; mh[1] = 0; ml[1] = 0; mdz[0] = 0; mdz[1] = 0;
    repeat (2) @(posedge clock);
    #1 snap(32, bsy, dn, dzo, h, l);
    chk("rst_busy", 64'(bsy), 64'd0);
    chk("rst_done", 64'(dn), 64'd0);
    chk("rst_dz", 64'(dzo), 64'd0);
    chk("rst_hi", h, 64'd0);
    chk("rst_lo", l, 64'd0);
    @(negedge clock) reset = 1'b1;

    run(32, 2'b00, 32'hFFFFFFFF, 32'd7, 0, 0);
    run(32, 2'b01, 32'hFFFFFFFF, 32'd7, 0, 0);
    run(32, 2'b10, 32'hFFFFFFF9, 32'd2, 0, 0);
    run(32, 2'b01, 32'hFFFFFFFF, 32'd7, 0, 0);
    run(32, 2'b11, 32'd100, 32'd0, 0, 0);
    run(32, 2'b01, 32'd5, 32'd6, 0, 0);
    run(32, 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run(32, 2'b10, 32'd7, 32'd0, 0, 0);
    run(32, 2'b11, 32'd9, 32'd2, 1, 4);
    run(32, 2'b00, 32'h12345678, 32'h9ABCDEF0, 2, 9);
    run(32, 2'b11, 32'hDEADBEEF, 32'd3, 2, 33);
    run(8, 2'b00, 32'h80, 32'h80, 0, 0);

    // start with abort in IDLE is not accepted
    @(negedge clock); op = 2'b01; a32 = 32'd2; b32 = 32'd2; start32 = 1'b1; abort = 1'b1;
    @(posedge clock); #1; start32 = 1'b0; abort = 1'b0;
    chk("sa_busy", 64'(busy32), 64'd0);
    chk("sa_done", 64'(done32), 64'd0);
    chk("sa_hi", 64'(hi32), 64'(mh[0]));

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(3))
        0: y = 32'd0;
        1: y = $urandom_range(15);
        default: y = $urandom;
      endcase
      run(32, 2'($urandom), (i % 4 == 0) ? 32'h80000000 : $urandom, y, 0, 0);
    end
    for (int i = 0; i < 12; i++)
      run(8, 2'($urandom), $urandom, (i % 5 == 0) ? 32'd0 : $urandom, 0, 0);

    // asynchronous reset mid-operation
    @(negedge clock); op = 2'b00; a32 = 32'd123; b32 = 32'd456; start32 = 1'b1;
    @(posedge clock); #1; start32 = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    #1 snap(32, bsy, dn, dzo, h, l);
    chk("mrst_busy", 64'(bsy), 64'd0);
    chk("mrst_done", 64'(dn), 64'd0);
    chk("mrst_dz", 64'(dzo), 64'd0);
    chk("mrst_hi", h, 64'd0);
    chk("mrst_lo", l, 64'd0);
    mh[0] = 0; ml[0] = 0; mh[1] = 0; ml[1] = 0;
    @(negedge clock) reset = 1'b1;
    run(32, 2'b10, 32'hFFFFFF9C, 32'd7, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that produces the HI/LO results for MULT/MULTU/DIV/DIVU in the multicycle MIPS datapath.
- Generalises the fixed 32-bit Div/Mult pair: configurable width, signed/unsigned modes, a start/busy/done handshake, a divide-by-zero flag and abort.
- The control unit issues start plus an op code, then waits on done. HI/LO are held internally as the architectural HI/LO registers.

Parameters:
- WIDTH, 32, operand width in bits. Any value ≥ 4. hi and lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- abort  in  1  synchronous cancel of an in-flight operation.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand or dividend).
- b  in  WIDTH  rt operand (multiplier or divisor).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  set when a DIV/DIVU had a zero divisor.
- hi  out  WIDTH  HI register: product high half or remainder.
- lo  out  WIDTH  LO register: product low half or quotient.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. Reset is effective mid-operation and discards the operation.
- States: IDLE, CALC, FIX. busy=1 exactly when state is CALC or FIX. done is registered and high only on the cycle after FIX.
- IDLE with start=1, normal case:
  - Latch op.
  - For signed ops, latch |a|, |b| and the result signs; unsigned ops use the raw operands.
  - counter=WIDTH; go to CALC; div_zero cleared.
- IDLE with start=1, DIV/DIVU and b==0:
  - Stay in IDLE; hi and lo unchanged.
  - div_zero=1 and done=1 on the next cycle.
  - div_zero holds until the next accepted start.
- CALC: one iteration per edge; counter decrements; when counter==1 the next state is FIX.
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per iteration.
- FIX, one edge: apply sign correction, write hi/lo, done=1, go to IDLE.
  - Multiply: {hi,lo} = full 2*WIDTH product, negated if the signs differ.
  - Divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed MIN / -1: lo=MIN (wraps), hi=0, no flag.
- Latency: done is visible WIDTH+2 cycles after the start-sampling edge (34 for WIDTH=32).
- start while busy: ignored; no queuing.
- start on the cycle done is high: accepted; done drops next cycle.
- abort=1 in CALC or FIX: go to IDLE next edge; hi/lo unchanged; no done. abort has priority over FIX completion. abort in IDLE has no effect, and abort also wins over a simultaneous start.
- Operands a, b and op may change after the start edge; the unit uses only latched copies.
- hi and lo change only on FIX completion or reset.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFF, b=7 -> busy for 33 cycles, done pulse at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFF9.
- MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFF9; then DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 with prior hi=6 -> done and div_zero=1 one cycle after start, busy never set, hi=6 unchanged. Next accepted MULTU clears div_zero.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Handshake edge cases:
  - start a DIVU 9/2, pulse start again at cycle 5 -> second start ignored, result lo=4, hi=1.
  - abort at cycle 10 -> no done, hi/lo keep old values.
  - reset low at cycle 10 -> all outputs 0 immediately.
- WIDTH=8 instance, MULT a=0x80, b=0x80 -> hi=0x40, lo=0x00, done at cycle 10.
